// File: rtl/dds_pkg.sv
// Shared types and constants for the DDS waveform generator.
package dds_pkg;

    // Waveform select encodings
    typedef enum logic [1:0] {
        MODE_SINE   = 2'd0,
        MODE_SQUARE = 2'd1,
        MODE_TRI    = 2'd2,
        MODE_SAW    = 2'd3
    } mode_e;

    // Control states: idle, free-running, retune waiting for phase wrap
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_e;

    localparam int         AMP_W     = 9;
    localparam logic [8:0] AMP_UNITY = 9'd256;
    localparam int         LATENCY   = 3;

    // Per-sample shaping attributes that travel down the pipeline with the phase
    typedef struct packed {
        mode_e            mode;
        logic [AMP_W-1:0] amp;
    } shape_t;

    localparam shape_t SHAPE_RST = '{mode: MODE_SINE, amp: AMP_UNITY};

    // Amplitudes above unity are treated as unity
    function automatic logic [AMP_W-1:0] clamp_amp(input logic [AMP_W-1:0] a);
        return (a > AMP_UNITY) ? AMP_UNITY : a;
    endfunction

endpackage

// File: rtl/dds_sine_lut.sv
// Full-scale offset-binary sine ROM with one-cycle registered read.
// Table contents are computed at elaboration: round(MID + (MID-1)*sin(2*pi*i/DEPTH)).
module dds_sine_lut #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 14
) (
    input  logic              i_clk,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] o_data
);
    localparam int  DEPTH = 1 << ADDR_W;
    localparam real PI    = 3.14159265358979323846;
    localparam real MIDF  = 1.0 * (1 << (DATA_W - 1));

    logic [DATA_W-1:0] w_rom [DEPTH];
    logic [DATA_W-1:0] r_data;

    for (genvar g = 0; g < DEPTH; g++) begin : g_rom
        localparam real ANG = (2.0 * PI * g) / DEPTH;
        localparam int  VAL = $rtoi(MIDF + (MIDF - 1.0) * $sin(ANG) + 0.5);
        assign w_rom[g] = DATA_W'(VAL);
    end

    // Registered ROM read; no reset so it maps onto block memory
    always_ff @(posedge i_clk) begin
        r_data <= w_rom[i_addr];
    end

    assign o_data = r_data;

endmodule

// File: rtl/dds_wave_gen.sv
// DDS waveform generator: phase accumulator, glitch-free retune via shadow
// config, waveform select, amplitude scaling, 3-stage pipeline to the DAC bus.
module dds_wave_gen
    import dds_pkg::*;
#(
    parameter int PHASE_W = 32,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 14
) (
    input  logic               i_dac_clk_in,
    input  logic               i_reset_n,
    input  logic               i_run,
    input  logic               i_cfg_valid,
    output logic               o_cfg_ready,
    input  logic [PHASE_W-1:0] i_cfg_ftw,
    input  logic [1:0]         i_cfg_mode,
    input  logic [8:0]         i_cfg_amp,
    input  logic               i_cfg_sync,
    output logic [DATA_W-1:0]  o_dac_db,
    output logic               o_dac_valid,
    output logic               o_wrap_pulse
);
    localparam logic [DATA_W-1:0] MID    = {1'b1, {(DATA_W-1){1'b0}}};
    localparam int                PROD_W = DATA_W + 1 + AMP_W + 1;

    // Control / phase state
    state_e              r_state;
    logic [PHASE_W-1:0]  r_acc;
    logic [PHASE_W-1:0]  r_ftw;
    shape_t              r_shape;
    logic [PHASE_W-1:0]  r_sh_ftw;
    shape_t              r_sh_shape;
    logic                r_cfg_ready;
    logic                r_wrap;

    // Pipeline
    logic [LATENCY:0]          r_vld_pipe;
    shape_t                    r_p0_shape;
    shape_t                    r_p1_shape;
    logic [DATA_W-1:0]         r_p1_wave;
    logic signed [PROD_W-1:0]  r_p2_prod;
    logic [DATA_W-1:0]         r_dac;

    logic [PHASE_W:0]          w_sum;
    logic                      w_carry;
    logic                      w_accept;
    shape_t                    w_cfg_shape;
    logic [DATA_W-1:0]         w_wave;
    logic [DATA_W-1:0]         w_lut;
    logic [DATA_W-1:0]         w_sample;
    logic signed [DATA_W:0]    w_s;

    assign w_sum    = {1'b0, r_acc} + {1'b0, r_ftw};
    assign w_carry  = w_sum[PHASE_W];
    assign w_accept = i_cfg_valid & r_cfg_ready;

    // Incoming config with the amplitude already clamped
    always_comb begin
        w_cfg_shape      = SHAPE_RST;
        w_cfg_shape.mode = mode_e'(i_cfg_mode);
        w_cfg_shape.amp  = clamp_amp(i_cfg_amp);
    end

    // FSM, accumulator, active/shadow config and wrap marker
    always_ff @(posedge i_dac_clk_in or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_ftw       <= '0;
            r_shape     <= SHAPE_RST;
            r_sh_ftw    <= '0;
            r_sh_shape  <= SHAPE_RST;
            r_cfg_ready <= 1'b1;
            r_wrap      <= 1'b0;
        end else begin
            r_wrap      <= 1'b0;
            r_cfg_ready <= 1'b1;
            unique case (r_state)
                IDLE: begin
                    r_acc <= '0;
                    if (w_accept) begin
                        r_ftw   <= i_cfg_ftw;
                        r_shape <= w_cfg_shape;
                    end
                    if (i_run) r_state <= RUN;
                end
                RUN: begin
                    if (!i_run) begin
                        // Leaving run: anything accepted now applies directly
                        r_state <= IDLE;
                        r_acc   <= '0;
                        if (w_accept) begin
                            r_ftw   <= i_cfg_ftw;
                            r_shape <= w_cfg_shape;
                        end
                    end else begin
                        r_acc  <= w_sum[PHASE_W-1:0];
                        r_wrap <= w_carry;
                        if (w_accept && i_cfg_sync) begin
                            // A carry on this same edge must not release it
                            r_sh_ftw    <= i_cfg_ftw;
                            r_sh_shape  <= w_cfg_shape;
                            r_state     <= PEND;
                            r_cfg_ready <= 1'b0;
                        end else if (w_accept) begin
                            r_ftw   <= i_cfg_ftw;
                            r_shape <= w_cfg_shape;
                        end
                    end
                end
                PEND: begin
                    if (!i_run) begin
                        // Shadow is never dropped: it lands on IDLE entry
                        r_state <= IDLE;
                        r_acc   <= '0;
                        r_ftw   <= r_sh_ftw;
                        r_shape <= r_sh_shape;
                    end else begin
                        r_acc  <= w_sum[PHASE_W-1:0];
                        r_wrap <= w_carry;
                        if (w_carry) begin
                            r_ftw   <= r_sh_ftw;
                            r_shape <= r_sh_shape;
                            r_state <= RUN;
                        end else begin
                            r_cfg_ready <= 1'b0;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // P0: tag the phase with the config that produced it; valid tracks run
    always_ff @(posedge i_dac_clk_in or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_p0_shape <= SHAPE_RST;
            r_vld_pipe <= '0;
        end else begin
            r_p0_shape <= r_shape;
            r_vld_pipe <= {r_vld_pipe[LATENCY-1:0], i_run};
        end
    end

    // Non-sine waveforms derived straight from the phase
    always_comb begin
        w_wave = '0;
        unique case (r_p0_shape.mode)
            MODE_SQUARE: w_wave = r_acc[PHASE_W-1] ? '0 : '1;
            MODE_TRI:    w_wave = r_acc[PHASE_W-1] ? ~r_acc[PHASE_W-2 -: DATA_W]
                                                   :  r_acc[PHASE_W-2 -: DATA_W];
            MODE_SAW:    w_wave = r_acc[PHASE_W-1 -: DATA_W];
            default:     w_wave = '0;
        endcase
    end

    dds_sine_lut #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_lut (
        .i_clk  (i_dac_clk_in),
        .i_addr (r_acc[PHASE_W-1 -: ADDR_W]),
        .o_data (w_lut)
    );

    // P1: register computed waveform alongside the LUT read
    always_ff @(posedge i_dac_clk_in or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_p1_wave  <= MID;
            r_p1_shape <= SHAPE_RST;
        end else begin
            r_p1_wave  <= w_wave;
            r_p1_shape <= r_p0_shape;
        end
    end

    assign w_sample = (r_p1_shape.mode == MODE_SINE) ? w_lut : r_p1_wave;
    assign w_s      = $signed({1'b0, w_sample}) - $signed({1'b0, MID});

    // P2: signed sample around midscale times amplitude
    always_ff @(posedge i_dac_clk_in or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_p2_prod <= '0;
        end else begin
            r_p2_prod <= w_s * $signed({1'b0, r_p1_shape.amp});
        end
    end

    // P3: rescale, re-centre and force midscale when not generating
    always_ff @(posedge i_dac_clk_in or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_dac <= MID;
        end else if (r_vld_pipe[LATENCY-1]) begin
            r_dac <= DATA_W'((r_p2_prod >>> 8) + $signed({{(PROD_W-DATA_W){1'b0}}, MID}));
        end else begin
            r_dac <= MID;
        end
    end

    assign o_cfg_ready  = r_cfg_ready;
    assign o_wrap_pulse = r_wrap;
    assign o_dac_db     = r_dac;
    assign o_dac_valid  = r_vld_pipe[LATENCY];

endmodule
